// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, opcodes and entry types for the fetch stage
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 24;

    localparam logic [3:0] OP_HALT = 4'b1110;
    localparam logic [3:0] OP_JMP  = 4'b1111;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] wa;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [7:0] imm;
    } instr_t;

    typedef struct packed {
        instr_t              word;
        logic [ADDR_W-1:0]   addr;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// rtl/instr_fetch_stage_if.sv - ROM read bus and decoded-instruction handshake
interface instr_fetch_stage_if;
    import fetch_pkg::*;

    logic                imem_rd;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_data;

    logic                out_valid;
    logic                out_ready;
    logic [3:0]          op;
    logic [3:0]          wa;
    logic [3:0]          ra1;
    logic [3:0]          ra2;
    logic [7:0]          imm;
    logic [ADDR_W-1:0]   pc_out;

    modport master (
        output imem_rd, imem_addr, out_valid, op, wa, ra1, ra2, imm, pc_out,
        input  imem_data, out_ready
    );

    modport slave (
        input  imem_rd, imem_addr, out_valid, op, wa, ra1, ra2, imm, pc_out,
        output imem_data, out_ready
    );

endinterface

// File: rtl/fetch_skid_fifo.sv
// rtl/fetch_skid_fifo.sv - two-entry instruction buffer with flush and combinational head
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          head_valid,
    output logic [1:0]    count
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != 2'd0);

endmodule

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - PC, credit-gated ROM issue, HALT/restart; JMP under FETCH_JUMP_EN
module instr_fetch_stage
    import fetch_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        restart,
    instr_fetch_stage_if.master         bus,
    output logic                        halted
);

    fetch_state_e       state;
    fetch_state_e       state_nxt;
    logic               live;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_nxt;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_addr;

    instr_t             land_word;
    fetch_entry_t       land_entry;
    logic               land_halt;
    logic               land_jmp;
    logic               land_ctrl;
    logic               push;
    logic               pop;
    logic               issue;
    logic               credit_ok;
    logic [2:0]         occupancy;
    logic [1:0]         count;
    logic               head_valid;
    fetch_entry_t       head;

    assign land_word  = instr_t'(bus.imem_data);
    assign land_entry = '{word: land_word, addr: inflight_addr};
    assign land_halt  = inflight && (land_word.op == OP_HALT);
`ifdef FETCH_JUMP_EN
    assign land_jmp   = inflight && (land_word.op == OP_JMP);
`else
    assign land_jmp   = 1'b0;
`endif
    assign land_ctrl  = land_halt || land_jmp;

    // Control words are consumed on landing; restart drops whatever lands
    assign push = inflight && !land_ctrl && !restart;
    assign pop  = bus.out_valid && bus.out_ready;

    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign credit_ok = occupancy < (3'd2 + {2'b00, pop});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = ST_RUN;
        end else if (land_halt) begin
            state_nxt = ST_HALT;
        end
    end

    always_comb begin
        issue  = 1'b0;
        halted = 1'b0;
        case (state)
            ST_RUN:  issue  = live && !restart && !land_ctrl && credit_ok;
            ST_HALT: halted = 1'b1;
            default: issue  = 1'b0;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (restart) begin
            pc_nxt = '0;
        end else if (land_jmp) begin
            pc_nxt = ADDR_W'(land_word.imm);
        end else if (issue) begin
            pc_nxt = pc + ADDR_W'(1);
        end
    end

    // live holds off the first issue until one full cycle after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live          <= 1'b0;
            pc            <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            live     <= 1'b1;
            pc       <= pc_nxt;
            inflight <= issue;
            if (issue) begin
                inflight_addr <= pc;
            end
        end
    end

    fetch_skid_fifo u_buf (
        .clk        (clk),
        .rst_n      (reset),
        .flush      (restart),
        .push       (push),
        .push_entry (land_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign bus.imem_rd   = issue;
    assign bus.imem_addr = pc;
    assign bus.out_valid = head_valid && !restart;
    assign bus.op        = head.word.op;
    assign bus.wa        = head.word.wa;
    assign bus.ra1       = head.word.ra1;
    assign bus.ra2       = head.word.ra2;
    assign bus.imm       = head.word.imm;
    assign bus.pc_out    = head.addr;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - randomized bench against a program-order fetch model
module tb_instr_fetch_stage;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic restart;
    logic halted;

    instr_fetch_stage_if bus ();

    instr_fetch_stage dut (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .bus     (bus),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    logic [INSTR_W-1:0] rom [256];
    logic [31:0]        exp_q [$];
    int                 tests_run    = 0;
    int                 tests_failed = 0;
    int                 cyc          = 0;
    int                 rd_count     = 0;
    int                 delivered    = 0;
    int                 last_pc      = -1;
    bit                 sb_on        = 1'b0;

    always @(posedge clk) begin
        if (bus.imem_rd) bus.imem_data <= rom[bus.imem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected delivery order: walk the program from start, skipping control words
    function automatic void build_expected(input int start, input int max_items);
        int a;
        logic [INSTR_W-1:0] w;
        a = start;
        exp_q.delete();
        for (int n = 0; n < max_items; n++) begin
            w = rom[a];
            if (w[23:20] == OP_HALT) break;
`ifdef FETCH_JUMP_EN
            if (w[23:20] == OP_JMP) begin
                a = int'(w[7:0]);
                continue;
            end
`endif
            exp_q.push_back({a[7:0], w});
            a = (a + 1) % 256;
        end
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) begin
            rom[i]        = INSTR_W'($urandom);
            rom[i][23:20] = 4'($urandom_range(0, 13));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        cyc++;
        if (bus.imem_rd) rd_count++;
        if (sb_on && bus.out_valid && bus.out_ready) begin
            delivered++;
            last_pc = int'(bus.pc_out);
            check_eq("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check_eq("deliver", {bus.pc_out, bus.op, bus.wa, bus.ra1, bus.ra2, bus.imm},
                         exp_q.pop_front());
        end
    endtask

    task automatic reset_cycle();
        reset         = 1'b0;
        restart       = 1'b0;
        bus.out_ready = 1'b0;
        sb_on         = 1'b0;
        settle();
        settle();
        delivered = 0;
        rd_count  = 0;
    endtask

    int n;
    int ha;
    int issue_c;
    int halt_c;
    int base;

    initial begin
        reset         = 1'b0;
        restart       = 1'b0;
        bus.out_ready = 1'b0;
        fill_rom();
        repeat (3) settle();
        check_eq("rst_ctrl", {bus.imem_rd, bus.out_valid, halted}, 3'b000);
        check_eq("rst_addr", {bus.imem_addr, bus.pc_out}, 16'h0000);
        check_eq("rst_fields", {bus.op, bus.wa, bus.ra1, bus.ra2, bus.imm}, 24'h0);

        // Startup latency and back-to-back streaming
        build_expected(0, 64);
        sb_on = 1'b1;
        reset = 1'b1;
        advance(); bus.out_ready = 1'b1; settle();
        check_eq("c1_rd", {bus.imem_rd, bus.out_valid}, 2'b10);
        check_eq("c1_addr", bus.imem_addr, 0);
        advance(); settle();
        check_eq("c2_valid", bus.out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            advance(); settle();
            check_eq("stream_pc", {bus.out_valid, bus.pc_out}, {1'b1, 8'(k)});
        end

        // Stall: buffer fills to two entries and issue stops
        fill_rom();
        reset_cycle();
        build_expected(0, 64);
        sb_on = 1'b1;
        reset = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            advance(); settle(); n++;
        end
        check_eq("first_valid_cyc", n, 3);
        repeat (5) begin advance(); settle(); end
        check_eq("stall_reads", rd_count, 2);
        check_eq("stall_head", {bus.out_valid, bus.pc_out}, {1'b1, 8'd0});
        advance(); bus.out_ready = 1'b1; settle();
        advance(); settle();
        advance(); settle();
        check_eq("stall_drain", delivered, 3);

        // HALT at address 2, then random positions with random backpressure
        for (int it = 0; it < 6; it++) begin
            ha = (it == 0) ? 2 : int'($urandom_range(3, 40));
            fill_rom();
            rom[ha][23:20] = OP_HALT;
            reset_cycle();
            build_expected(0, 256);
            sb_on   = 1'b1;
            reset   = 1'b1;
            issue_c = -100;
            halt_c  = -1;
            n       = 0;
            while (!(halted && exp_q.size() == 0) && n < 400) begin
                advance();
                bus.out_ready = ($urandom_range(0, 3) != 0);
                settle();
                n++;
                if (bus.imem_rd && int'(bus.imem_addr) == ha) issue_c = cyc;
                if (halted && halt_c < 0) halt_c = cyc;
            end
            check_eq("halt_drained", exp_q.size(), 0);
            check_eq("halt_latency", halt_c - issue_c, 2);
            base = rd_count;
            repeat (5) begin advance(); settle(); end
            check_eq("halt_no_issue", rd_count - base, 0);
            check_eq("halt_pc", {halted, bus.imem_addr}, {1'b1, 8'(ha + 1)});

            if (it == 0) begin
                // Restart out of HALT
                advance(); restart = 1'b1; bus.out_ready = 1'b1; build_expected(0, 256); settle();
                check_eq("rs_halt_cycle", {bus.out_valid, bus.imem_rd}, 2'b00);
                advance(); restart = 1'b0; bus.out_ready = 1'b0; settle();
                check_eq("rs_halt_resume", {halted, bus.imem_rd, bus.imem_addr}, {1'b0, 1'b1, 8'd0});
                repeat (4) begin advance(); settle(); end
                check_eq("rs_buf_full", {bus.out_valid, bus.pc_out}, {1'b1, 8'd0});
                // Restart with two entries buffered and downstream ready
                advance(); restart = 1'b1; bus.out_ready = 1'b1; build_expected(0, 256); settle();
                check_eq("rs_buf_cycle", {bus.out_valid, bus.imem_rd}, 2'b00);
                advance(); restart = 1'b0; settle();
                check_eq("rs_buf_resume", {halted, bus.out_valid, bus.imem_rd, bus.imem_addr},
                         {1'b0, 1'b0, 1'b1, 8'd0});
                n = 0;
                while (!(halted && exp_q.size() == 0) && n < 100) begin
                    advance(); settle(); n++;
                end
                check_eq("rs_drained", {halted, 24'(exp_q.size())}, {1'b1, 24'd0});
            end
        end

        // PC wrap: run through 255, address 0 turns into HALT after its first fetch
        fill_rom();
        reset_cycle();
        build_expected(0, 256);
        sb_on = 1'b1;
        reset = 1'b1;
        advance(); bus.out_ready = 1'b1; settle();
        repeat (5) begin advance(); settle(); end
        rom[0][23:20] = OP_HALT;
        n = 0;
        while (!(halted && exp_q.size() == 0) && n < 400) begin
            advance(); settle(); n++;
        end
        check_eq("wrap_drained", exp_q.size(), 0);
        check_eq("wrap_last_pc", last_pc, 255);
        check_eq("wrap_halt", {halted, bus.imem_addr}, {1'b1, 8'd1});

        // JMP program: delivered 0,10,11 when jumps are compiled in, else 0,1,2
        fill_rom();
        rom[1]  = {OP_JMP, 12'($urandom), 8'd10};
        rom[3][23:20]  = OP_HALT;
        rom[12][23:20] = OP_HALT;
        reset_cycle();
        build_expected(0, 256);
        sb_on = 1'b1;
        reset = 1'b1;
        n = 0;
        while (!(halted && exp_q.size() == 0) && n < 200) begin
            advance();
            bus.out_ready = ($urandom_range(0, 1) != 0);
            settle();
            n++;
        end
        check_eq("jmp_drained", exp_q.size(), 0);
        check_eq("jmp_count", delivered, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
